// File: rtl/ram_input_ctrl.sv
// ram_input_ctrl: conditions raw board inputs (push-button, slide switches) into
// clean RAM controls for the RAM/7-seg display block: 2-flop synchronizers,
// key debounce, a single-cycle write strobe and stable address/data/mode.
// Optional build macro: AUTO_INC_EN (address from an internal auto-incrementing
// pointer instead of the address switches).
module ram_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AW              = 4,
  parameter int DW              = 4
) (
  input  logic          clock_in,
  input  logic          reset_n,
  input  logic          key_n,
  input  logic [AW-1:0] sw_addr,
  input  logic [DW-1:0] sw_data,
  input  logic          sw_mode,
  output logic [AW-1:0] address,
  output logic [DW-1:0] data_in,
  output logic          mode,
  output logic          we,
  output logic          busy
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Synchronizer stages
  logic          key_meta_q,  key_sync_q;
  logic          mode_meta_q, mode_sync_q;
  logic [AW-1:0] addr_meta_q, addr_sync_q;
  logic [DW-1:0] data_meta_q, data_sync_q;

  // Debounce state (key_db_q: 1 = released, 0 = pressed)
  logic          key_db_q, key_db_d;
  logic [CW-1:0] cnt_q,    cnt_d;

  // FSM and registered outputs
  state_t        state_q,   state_d;
  logic [AW-1:0] address_q, address_d;
  logic [DW-1:0] data_in_q, data_in_d;
  logic          we_q,      we_d;
  logic          busy_q,    busy_d;
  logic [AW-1:0] sel_addr;

`ifdef AUTO_INC_EN
  logic [AW-1:0] ptr_q, ptr_d;
  assign sel_addr = ptr_q;
`else
  assign sel_addr = addr_sync_q;
`endif

  // Two-flop synchronizers; key idles high (released), everything else low.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      key_meta_q  <= 1'b1;
      key_sync_q  <= 1'b1;
      mode_meta_q <= 1'b0;
      mode_sync_q <= 1'b0;
      addr_meta_q <= '0;
      addr_sync_q <= '0;
      data_meta_q <= '0;
      data_sync_q <= '0;
    end else begin
      key_meta_q  <= key_n;
      key_sync_q  <= key_meta_q;
      mode_meta_q <= sw_mode;
      mode_sync_q <= mode_meta_q;
      addr_meta_q <= sw_addr;
      addr_sync_q <= addr_meta_q;
      data_meta_q <= sw_data;
      data_sync_q <= data_meta_q;
    end
  end

  // Debounce: the synced key must disagree with the accepted level for
  // DEBOUNCE_CYCLES consecutive clocks before the new level is taken.
  always_comb begin
    key_db_d = key_db_q;
    cnt_d    = cnt_q;
    if (key_sync_q == key_db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      key_db_d = key_sync_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Debounce registers.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      key_db_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      key_db_q <= key_db_d;
      cnt_q    <= cnt_d;
    end
  end

  // FSM next state: HOLD is only left on release, so a pressed level seen in
  // IDLE is always a fresh press edge and each press yields one action.
  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    data_in_d = data_in_q;
    we_d      = 1'b0;
`ifdef AUTO_INC_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        address_d = sel_addr;
        if (!key_db_q) begin
          if (mode_sync_q) begin
            state_d   = ST_WRITE;
            we_d      = 1'b1;
            data_in_d = data_sync_q;
          end else begin
            state_d = ST_HOLD;
`ifdef AUTO_INC_EN
            ptr_d   = ptr_q + AW'(1);
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_d = ST_HOLD;
`ifdef AUTO_INC_EN
        ptr_d   = ptr_q + AW'(1);
`endif
      end
      ST_HOLD: begin
        if (key_db_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state and registered outputs; reset clears we/busy asynchronously.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      address_q <= '0;
      data_in_q <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
`ifdef AUTO_INC_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      data_in_q <= data_in_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
`ifdef AUTO_INC_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign address = address_q;
  assign data_in = data_in_q;
  assign mode    = mode_sync_q;
  assign we      = we_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_ram_input_ctrl.sv
// Directed testbench for ram_input_ctrl with DEBOUNCE_CYCLES=4, so the
// key_n-low-to-we latency is 2 + 4 + 1 = 7 clocks. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_ram_input_ctrl;

  localparam int DC = 4;
  localparam int AW = 4;
  localparam int DW = 4;

  logic          clock_in;
  logic          reset_n;
  logic          key_n;
  logic [AW-1:0] sw_addr;
  logic [DW-1:0] sw_data;
  logic          sw_mode;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic          mode;
  logic          we;
  logic          busy;

  int checks = 0;
  int errors = 0;

  ram_input_ctrl #(.DEBOUNCE_CYCLES(DC), .AW(AW), .DW(DW)) dut (
    .clock_in(clock_in), .reset_n(reset_n), .key_n(key_n),
    .sw_addr(sw_addr), .sw_data(sw_data), .sw_mode(sw_mode),
    .address(address), .data_in(data_in), .mode(mode),
    .we(we), .busy(busy)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  // Hold key_n low for n clocks; report first we cycle, we-high count,
  // first busy cycle and address/data_in seen during the first we pulse.
  task automatic hold_key(input int n, output int first_we, output int we_hi,
                          output int busy_first, output logic [AW-1:0] a_we,
                          output logic [DW-1:0] d_we);
    first_we = -1; we_hi = 0; busy_first = -1; a_we = '0; d_we = '0;
    key_n = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clock_in);
      if (we === 1'b1) begin
        we_hi++;
        if (first_we < 0) begin
          first_we = k; a_we = address; d_we = data_in;
        end
      end
      if (busy === 1'b1 && busy_first < 0) busy_first = k;
    end
  endtask

  // Wait (bounded) for busy to return low.
  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock_in);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; key_n = 1'b1; sw_mode = 1'b1; sw_addr = 4'd5; sw_data = 4'd9;
    wait_cycles(3);
    checks++;
    if ({address, data_in, mode, we, busy} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%0d data=%0d mode=%b we=%b busy=%b, want all 0",
               address, data_in, mode, we, busy);
    end
    reset_n = 1'b1;
    wait_cycles(1);
    checks++;
    if (busy !== 1'b0 || we !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got we=%b busy=%b, want 0 0", we, busy);
    end
    wait_cycles(4);
  endtask

`ifdef AUTO_INC_EN
  task automatic test_auto_inc;
    int fw, wh, bf;
    logic [AW-1:0] a; logic [DW-1:0] d;
    logic [AW-1:0] exp_a;
    bit ok;
    sw_mode = 1'b1;
    for (int i = 0; i < 17; i++) begin
      sw_data = DW'(i);
      wait_cycles(3);
      hold_key(12, fw, wh, bf, a, d);
      exp_a = AW'(i);
      checks++;
      if (wh !== 1 || a !== exp_a) begin
        errors++;
        $display("FAIL auto_inc_press%0d: got we_cycles=%0d addr=%0d, want 1 and %0d", i, wh, a, exp_a);
      end
      key_n = 1'b1;
      wait_idle(20, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL auto_inc_idle%0d: busy=%b, want 0 within 20 clk", i, busy);
      end
    end
    wait_cycles(3);
    checks++;
    if (address !== 4'd1) begin
      errors++;
      $display("FAIL auto_inc_final_addr: got %0d, want 1", address);
    end
  endtask
`endif

  task automatic test_write;
    int fw, wh, bf;
    logic [AW-1:0] a; logic [DW-1:0] d;
    bit ok;
    sw_mode = 1'b1; sw_addr = 4'd5; sw_data = 4'd9; key_n = 1'b1;
    wait_cycles(4);
    hold_key(20, fw, wh, bf, a, d);
    checks++;
    if (fw !== 7) begin
      errors++;
      $display("FAIL write_latency: got we at clk %0d, want 7", fw);
    end
    checks++;
    if (wh !== 1) begin
      errors++;
      $display("FAIL write_single_pulse: got %0d we cycles, want 1", wh);
    end
`ifndef AUTO_INC_EN
    checks++;
    if (a !== 4'd5) begin
      errors++;
      $display("FAIL write_addr: got %0d, want 5", a);
    end
`endif
    checks++;
    if (d !== 4'd9) begin
      errors++;
      $display("FAIL write_data: got %0d, want 9", d);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL write_busy_hold: got %b, want 1", busy);
    end
    key_n = 1'b1;
    wait_idle(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL write_release: busy=%b, want 0 within 20 clk", busy);
    end
    wait_cycles(2);
  endtask

  task automatic test_glitch;
    int wh = 0, bh = 0;
    sw_mode = 1'b1;
    wait_cycles(3);
    key_n = 1'b0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clock_in);
      if (k == 2) key_n = 1'b1;
      if (we === 1'b1) wh++;
      if (busy === 1'b1) bh++;
    end
    checks++;
    if (wh !== 0 || bh !== 0) begin
      errors++;
      $display("FAIL glitch_rejected: got we cycles=%0d busy cycles=%0d, want 0 0", wh, bh);
    end
  endtask

  task automatic test_min_press;
    int wh = 0, fw = -1;
    bit ok;
    sw_mode = 1'b1; sw_data = 4'd4;
    wait_cycles(3);
    key_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock_in);
      if (k == 4) key_n = 1'b1;
      if (we === 1'b1) begin
        wh++;
        if (fw < 0) fw = k;
      end
    end
    checks++;
    if (wh !== 1 || fw !== 7) begin
      errors++;
      $display("FAIL min_press_accepted: got we cycles=%0d first=%0d, want 1 at 7", wh, fw);
    end
    wait_idle(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL min_press_idle: busy=%b, want 0 within 20 clk", busy);
    end
    wait_cycles(2);
  endtask

  task automatic test_long_hold;
    int wh = 0, fw = -1, unstable = 0;
    logic [AW-1:0] a_cap;
    bit ok;
    a_cap = '0;
    sw_mode = 1'b1; sw_addr = 4'd10; sw_data = 4'd6;
    wait_cycles(4);
    key_n = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock_in);
      if (k == 30) begin
        sw_mode = 1'b0; sw_data = 4'd3; sw_addr = 4'd2;
      end
      if (we === 1'b1) begin
        wh++;
        if (fw < 0) begin
          fw = k; a_cap = address;
        end
      end
      if (fw > 0 && (address !== a_cap || data_in !== 4'd6)) unstable++;
    end
    checks++;
    if (wh !== 1 || fw !== 7) begin
      errors++;
      $display("FAIL long_hold_single_we: got we cycles=%0d first=%0d, want 1 at 7", wh, fw);
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL long_hold_stable: got %0d unstable cycles, want 0", unstable);
    end
`ifndef AUTO_INC_EN
    checks++;
    if (address !== 4'd10 || data_in !== 4'd6) begin
      errors++;
      $display("FAIL long_hold_regs: got addr=%0d data=%0d, want 10 6", address, data_in);
    end
`endif
    key_n = 1'b1;
    wait_idle(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL long_hold_release: busy=%b, want 0 within 20 clk", busy);
    end
    wait_cycles(3);
`ifndef AUTO_INC_EN
    checks++;
    if (address !== 4'd2) begin
      errors++;
      $display("FAIL idle_addr_track: got %0d, want 2", address);
    end
`endif
  endtask

  task automatic test_read;
    int fw, wh, bf;
    logic [AW-1:0] a; logic [DW-1:0] d;
    bit ok;
    sw_mode = 1'b1; sw_addr = 4'd7;
    wait_cycles(4);
    sw_mode = 1'b0;
    wait_cycles(1);
    checks++;
    if (mode !== 1'b1) begin
      errors++;
      $display("FAIL mode_latency1: got %b, want 1 one clk after switch", mode);
    end
    wait_cycles(1);
    checks++;
    if (mode !== 1'b0) begin
      errors++;
      $display("FAIL mode_latency2: got %b, want 0 two clk after switch", mode);
    end
    wait_cycles(2);
    hold_key(20, fw, wh, bf, a, d);
    checks++;
    if (wh !== 0) begin
      errors++;
      $display("FAIL read_no_we: got %0d we cycles, want 0", wh);
    end
    checks++;
    if (bf !== 7) begin
      errors++;
      $display("FAIL read_busy: got busy first at clk %0d, want 7", bf);
    end
`ifndef AUTO_INC_EN
    checks++;
    if (address !== 4'd7) begin
      errors++;
      $display("FAIL read_addr: got %0d, want 7", address);
    end
`endif
    key_n = 1'b1;
    wait_idle(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL read_release: busy=%b, want 0 within 20 clk", busy);
    end
    wait_cycles(2);
  endtask

  task automatic test_reset_mid_hold;
    int fw, wh, bf;
    logic [AW-1:0] a; logic [DW-1:0] d;
    sw_mode = 1'b1; sw_addr = 4'd3; sw_data = 4'd12;
    wait_cycles(4);
    hold_key(15, fw, wh, bf, a, d);
    checks++;
    if (wh !== 1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_hold: got we cycles=%0d busy=%b, want 1 1", wh, busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({address, data_in, mode, we, busy} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid_hold: got addr=%0d data=%0d mode=%b we=%b busy=%b, want all 0",
               address, data_in, mode, we, busy);
    end
    key_n = 1'b1;
    wait_cycles(1);
    reset_n = 1'b1;
    wait_cycles(1);
    checks++;
    if (busy !== 1'b0 || we !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: got we=%b busy=%b, want 0 0", we, busy);
    end
    wait_cycles(4);
  endtask

  task automatic test_reset_in_write;
    int fw, wh, bf;
    logic [AW-1:0] a; logic [DW-1:0] d;
    sw_mode = 1'b1;
    wait_cycles(3);
    hold_key(7, fw, wh, bf, a, d);
    checks++;
    if (fw !== 7 || we !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_write: got first we=%0d we=%b, want 7 1", fw, we);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_we: got we=%b busy=%b, want 0 0", we, busy);
    end
    key_n = 1'b1;
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(4);
  endtask

  initial begin
    test_reset;
`ifdef AUTO_INC_EN
    test_auto_inc;
`endif
    test_write;
    test_glitch;
    test_min_press;
    test_long_hold;
    test_read;
    test_reset_mid_hold;
    test_reset_in_write;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
